fpnew_slice_result_arbiter: RTL and testbench
=============================================

# fpnew_slice_result_arbiter

Round-robin arbiter and output register that consumes the per-format slice outputs of one operation group. It merges them into a single registered result stream for the FPU top-level output. Each input is one format slice's result/status/extension-bit/tag bundle with a valid/ready handshake. The block grants at most one slice per cycle and holds the winner in a one-entry output register. It sustains one result per cycle.

## Interface
Parameters:
- NumInputs, 4, number of slice result ports (≥2)
- Width, 32, result width in bits
- TagType, 1, tag MSB index; tags are TagType+1 bits wide

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- results_i  in  NumInputs×Width  slice results
- status_i  in  NumInputs×fpnew_pkg::status_t  slice status flags
- ext_bit_i  in  NumInputs  slice extension bits
- tags_i  in  NumInputs×(TagType+1)  slice tags
- in_valid_i  in  NumInputs  slice out_valid
- in_ready_o  out  NumInputs  ready back to slices (one-hot or zero)
- flush_i  in  1  pipeline flush
- result_o  out  Width  registered result
- status_o  out  status_t  registered status
- extension_bit_o  out  1  registered extension bit
- tag_o  out  TagType+1  registered tag
- out_valid_o  out  1  output register holds data
- out_ready_i  in  1  downstream ready
- busy_o  out  1  output register occupied or any in_valid_i high

## Operation
- Register state: valid bit q_valid, data fields (result, status, ext bit, tag), round-robin pointer prio (⌈log2 NumInputs⌉ bits).
- Load enable: load_ok = ~q_valid | out_ready_i. When flush_i=1, load_ok is forced to 0.
- Arbitration is combinational. Winner = first index i with in_valid_i[i]=1, scanning prio, prio+1, …, wrapping modulo NumInputs.
- If load_ok and any input is valid:
  - in_ready_o[winner]=1; all other bits are 0.
  - The winner's bundle loads into the register; q_valid←1.
  - prio←(winner+1) mod NumInputs.
- If load_ok and no input is valid: q_valid←0 when out_ready_i=1; prio is unchanged.
- If ~load_ok: in_ready_o is all zero and the register holds. Outputs stay stable while out_valid_o=1 and out_ready_i=0 (AXI-style hold).
- Simultaneous drain and load in one cycle: the register is overwritten with the new winner and q_valid stays 1.
- flush_i=1: q_valid←0 next edge and no grant is issued. prio is not changed by the flush.
- Data fields are not cleared on drain or flush. Only q_valid is authoritative.
- in_valid_i is not required to stay stable. An ungranted input may drop valid; the arbiter re-evaluates every cycle.

## Timing
- Latency: 1 cycle from grant edge to out_valid_o.
- Throughput: 1 result/cycle under continuous out_ready_i=1.
- in_ready_o has a combinational path from in_valid_i, out_ready_i and flush_i. There is no combinational path from in_valid_i to out_valid_o.
- Fairness: a continuously valid input is granted within NumInputs grants.
- Reset values: out_valid_o=0, result_o='0, status_o='0, extension_bit_o=0, tag_o='0, prio=0, busy_o=0 while all in_valid_i=0.
- Reset asserted mid-transfer: the register empties immediately (asynchronous). Any in-flight result is dropped; upstream flush is handled separately.

## Structure
- Use fpnew_pkg::status_t; no new typedefs are needed.
- Add to fpnew_pkg: function `clog2_min1(n)`, returning the pointer width with a floor of 1.
- Sub-module fpnew_rr_select, combinational. Inputs: req vector and prio. Outputs: one-hot gnt and binary idx. The pointer register lives in the top module.

## Test plan
- Reset: hold rst_ni=0 with all inputs driven → all outputs 0, in_ready_o=0. Release → with in_valid_i=4'b0001, grant[0] next cycle and out_valid_o=1 one cycle later.
- Round-robin: in_valid_i=4'b1111 continuously, out_ready_i=1 → grant order 0,1,2,3,0. Tags 0..3 appear on tag_o in the same order, one per cycle.
- Backpressure: register full, out_ready_i=0 for 3 cycles with result_o=32'h3F80_0000 → result_o stable, in_ready_o=0. Raise out_ready_i → the next winner loads in the same cycle, with no bubble.
- Partial requests: prio=2, in_valid_i=4'b0011 → grant 0, then prio=1 → next grant 1.
- Flush: out_valid_o=1 and in_valid_i=4'b0100 with flush_i=1 → no grant; out_valid_o=0 next cycle; prio unchanged.
- Status passthrough: input 1 with status NV=1, OF=0, tag=2'b10, ext_bit=1 → same values on status_o, tag_o and extension_bit_o one cycle after grant.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE exception status flags and a pointer-width helper.
package fpnew_pkg;

  typedef struct packed {
    logic NV;  // invalid operation
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

  // Width of an index into n entries, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpnew_rr_select.sv
// Combinational round-robin select: first requester at or after prio, wrapping.
module fpnew_rr_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] prio,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW:0] pos;
  logic        found;

  // NOTE: every output and loop temporary gets a default before the scan so
  // no path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int off = 0; off < int'(N); off++) begin
      pos = {1'b0, prio} + (PW+1)'(off);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && req[pos[PW-1:0]]) begin
        found             = 1'b1;
        gnt[pos[PW-1:0]]  = 1'b1;
        idx               = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fpnew_slice_result_arbiter.sv
// Merges per-format slice results into one registered stream, one grant per cycle.
module fpnew_slice_result_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumInputs = 4,
  parameter int unsigned Width     = 32,
  parameter int unsigned TagType   = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumInputs-1:0][Width-1:0]     results_i,
  input  status_t [NumInputs-1:0]             status_i,
  input  logic [NumInputs-1:0]                ext_bit_i,
  input  logic [NumInputs-1:0][TagType:0]     tags_i,
  input  logic [NumInputs-1:0]                in_valid_i,
  output logic [NumInputs-1:0]                in_ready_o,
  input  logic                                flush_i,
  output logic [Width-1:0]                    result_o,
  output status_t                             status_o,
  output logic                                extension_bit_o,
  output logic [TagType:0]                    tag_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                busy_o
);

  localparam int unsigned PtrW = clog2_min1(NumInputs);

  logic [NumInputs-1:0] gnt;
  logic [PtrW-1:0]      win_idx;
  logic [PtrW-1:0]      prio_q;
  logic                 q_valid;
  logic                 load_ok;
  logic                 any_req;

  fpnew_rr_select #(
    .N  (NumInputs),
    .PW (PtrW)
  ) u_rr_select (
    .req  (in_valid_i),
    .prio (prio_q),
    .gnt  (gnt),
    .idx  (win_idx)
  );

  assign any_req = |in_valid_i;
  // Reset gates the handshake so nothing is acknowledged while held in reset.
  assign load_ok    = rst_ni & ~flush_i & (~q_valid | out_ready_i);
  assign in_ready_o = load_ok ? gnt : '0;
  assign busy_o     = rst_ni & (q_valid | any_req);

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; the small output register is reset since zeros are visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_valid         <= 1'b0;
      prio_q          <= '0;
      result_o        <= '0;
      status_o        <= '0;
      extension_bit_o <= 1'b0;
      tag_o           <= '0;
    end else if (load_ok) begin
      if (any_req) begin
        q_valid         <= 1'b1;
        result_o        <= results_i[win_idx];
        status_o        <= status_i[win_idx];
        extension_bit_o <= ext_bit_i[win_idx];
        tag_o           <= tags_i[win_idx];
        prio_q          <= (win_idx == PtrW'(NumInputs - 1)) ? '0 : win_idx + 1'b1;
      end else if (out_ready_i) begin
        q_valid <= 1'b0;
      end
    end else if (flush_i) begin
      // Data fields are left stale; only q_valid is authoritative.
      q_valid <= 1'b0;
    end
  end

  assign out_valid_o = q_valid;

endmodule

// File: tb/tb_fpnew_slice_result_arbiter.sv
// Directed bench for the slice result arbiter with an expected-result queue.
module tb_fpnew_slice_result_arbiter;
  import fpnew_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    status_t     st;
    logic        ext;
    logic [1:0]  tag;
  } bundle_t;

  logic                  clk;
  logic                  rst_ni;
  logic [3:0][31:0]      results;
  status_t [3:0]         status;
  logic [3:0]            ext_bit;
  logic [3:0][1:0]       tags;
  logic [3:0]            in_valid;
  logic [3:0]            in_ready;
  logic                  flush;
  logic [31:0]           result;
  status_t               status_q;
  logic                  ext_q;
  logic [1:0]            tag_q;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  int      errors = 0;
  int      checks = 0;
  bundle_t sb_q[$];
  logic    m_qvalid = 1'b0;

  fpnew_slice_result_arbiter #(
    .NumInputs (4),
    .Width     (32),
    .TagType   (1)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .results_i       (results),
    .status_i        (status),
    .ext_bit_i       (ext_bit),
    .tags_i          (tags),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .flush_i         (flush),
    .result_o        (result),
    .status_o        (status_q),
    .extension_bit_o (ext_q),
    .tag_o           (tag_q),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One cycle: compare at the falling edge, update the expected-state model,
  // then return just after the rising edge so the caller can change inputs.
  task automatic step(input logic [3:0] exp_gnt, input string name);
    bundle_t b;
    @(negedge clk);
    check({name, " in_ready"}, 64'(in_ready), 64'(exp_gnt));
    check({name, " out_valid"}, 64'(out_valid), 64'(m_qvalid));
    if (m_qvalid) begin
      if (sb_q.size() == 0) begin
        check({name, " queue_empty"}, 64'(1), 64'(0));
      end else begin
        b = sb_q[0];
        check({name, " result"}, 64'(result), 64'(b.res));
        check({name, " status"}, 64'(status_q), 64'(b.st));
        check({name, " ext"}, 64'(ext_q), 64'(b.ext));
        check({name, " tag"}, 64'(tag_q), 64'(b.tag));
        if (out_ready || flush) void'(sb_q.pop_front());
      end
    end
    if (flush) begin
      m_qvalid = 1'b0;
    end else if (exp_gnt != 4'b0000) begin
      m_qvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (exp_gnt[i]) begin
          b.res = results[i];
          b.st  = status[i];
          b.ext = ext_bit[i];
          b.tag = tags[i];
          sb_q.push_back(b);
        end
      end
    end else if (out_ready) begin
      m_qvalid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    results[0] = 32'h3F80_0000;
    results[1] = 32'h4000_0000;
    results[2] = 32'h4040_0000;
    results[3] = 32'h4080_0000;
    for (int i = 0; i < 4; i++) begin
      status[i] = status_t'(5'(i + 1));
      tags[i]   = 2'(i);
    end
    ext_bit = 4'b0101;

    // Reset held with inputs active: everything quiet.
    #12;
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(0));
    check("rst result", 64'(result), 64'(0));
    check("rst status", 64'(status_q), 64'(0));
    check("rst ext", 64'(ext_q), 64'(0));
    check("rst tag", 64'(tag_q), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_ni   = 1'b1;
    in_valid = 4'b0001;
    step(4'b0001, "first_grant");
    // Grant input 3 so the pointer wraps back to 0.
    in_valid = 4'b1000;
    step(4'b1000, "wrap3");

    // Round robin with all inputs requesting.
    in_valid = 4'b1111;
    step(4'b0001, "rr0");
    step(4'b0010, "rr1");
    step(4'b0100, "rr2");
    step(4'b1000, "rr3");
    step(4'b0001, "rr0b");

    // Backpressure: input 0 (1.0f) held for three cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, "hold");
      check("hold result", 64'(result), 64'h3F80_0000);
    end
    out_ready = 1'b1;
    step(4'b0010, "release");

    // Partial requests starting from pointer 2.
    in_valid = 4'b0011;
    step(4'b0001, "partial0");
    step(4'b0010, "partial1");

    // Flush with a full register and a pending request.
    in_valid  = 4'b0100;
    flush     = 1'b1;
    out_ready = 1'b0;
    step(4'b0000, "flush");
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b0000;
    step(4'b0000, "post_flush");
    in_valid = 4'b1111;
    step(4'b0100, "prio_kept");
    in_valid = 4'b0000;
    step(4'b0000, "drain2");

    // Status/tag/extension passthrough from input 1.
    status[1]  = status_t'(5'b10000);
    tags[1]    = 2'b10;
    ext_bit[1] = 1'b1;
    in_valid   = 4'b0010;
    step(4'b0010, "pass_grant");
    check("pass NV", 64'(status_q.NV), 64'(1));
    check("pass OF", 64'(status_q.OF), 64'(0));
    check("pass tag", 64'(tag_q), 64'(2'b10));
    check("pass ext", 64'(ext_q), 64'(1));
    in_valid = 4'b0000;
    step(4'b0000, "pass_out");

    // Busy reflects pending requests even with an empty register.
    check("busy idle", 64'(busy), 64'(0));
    in_valid = 4'b0100;
    #1;
    check("busy req", 64'(busy), 64'(1));
    step(4'b0100, "pre_reset");

    // Asynchronous reset in the middle of a transfer.
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'(0));
    check("midrst result", 64'(result), 64'(0));
    sb_q.delete();
    m_qvalid = 1'b0;
    in_valid = 4'b0000;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 4'b0011;
    step(4'b0001, "after_rst");
    in_valid = 4'b0000;
    step(4'b0000, "final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
